// File: rtl/rl_fifo2stream.sv
// rl_fifo2stream: read-side adapter that turns a fixed-latency FIFO read port into a bubble-free valid/ready stream.
// Optional build macro RL_FIFO2STREAM_STATS_EN adds transfer and stall counters.
module rl_fifo2stream #(
    parameter int DATA_SIZE  = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic                           fifo_empty_i,
    output logic                           fifo_rdena_o,
    input  logic [DATA_SIZE-1:0]           fifo_q_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [DATA_SIZE-1:0]           m_data_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level_o
`ifdef RL_FIFO2STREAM_STATS_EN
    ,
    output logic [31:0]                    xfer_cnt_o,
    output logic [31:0]                    stall_cnt_o
`endif
);

    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    if (BUF_DEPTH < RD_LATENCY) begin : g_depth_chk
        $error("rl_fifo2stream: BUF_DEPTH must be >= RD_LATENCY");
    end

    logic [DATA_SIZE-1:0]  mem_q [BUF_DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [LW-1:0]         level_q, level_d;
    logic [RD_LATENCY-1:0] infl_q, infl_d;
    logic                  pop, issue, capture;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (int'(p) == BUF_DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    assign pop     = m_valid_o & m_ready_i;
    assign capture = infl_q[RD_LATENCY-1];
    // Credit: buffered words plus reads still in flight must fit after this cycle's pop.
    assign issue   = ~rst_i & ~fifo_empty_i & ~clr_i &
                     ((int'(level_q) + $countones(infl_q) - int'(pop)) < BUF_DEPTH);

    if (RD_LATENCY == 1) begin : g_infl_l1
        assign infl_d = issue;
    end else begin : g_infl_ln
        assign infl_d = {infl_q[RD_LATENCY-2:0], issue};
    end

    always_comb begin
        head_d  = pop ? ptr_inc(head_q) : head_q;
        tail_d  = capture ? ptr_inc(tail_q) : tail_q;
        level_d = level_q;
        case ({capture, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            infl_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            infl_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            infl_q  <= infl_d;
            if (capture) mem_q[tail_q] <= fifo_q_i;
        end
    end

    assign fifo_rdena_o = issue;
    assign m_valid_o    = (level_q != '0);
    assign m_data_o     = mem_q[head_q];
    assign level_o      = level_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        (int'(level_q) + $countones(infl_q)) <= BUF_DEPTH);

`ifdef RL_FIFO2STREAM_STATS_EN
    logic [31:0] xfer_q, stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else if (clr_i) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop) xfer_q <= xfer_q + 32'd1;
            if (m_valid_o & ~m_ready_i & (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign xfer_cnt_o  = xfer_q;
    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_rl_fifo2stream.sv
// Bench for rl_fifo2stream: two instances (latency 1 / depth 2 and latency 2 / depth 3) fed by a
// behavioural FIFO; emitted words are scored against the ordered list of words written, flushed on clear.
module tb_rl_fifo2stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  clr, empty, rdena, valid, ready;
    logic [31:0] q0, q1, d0, d1;
    logic [1:0]  lvl0, lvl1;
`ifdef RL_FIFO2STREAM_STATS_EN
    logic [31:0] xfer0, stall0, xfer1, stall1;
    logic [31:0] xfer_m [2];
    logic [31:0] stall_m [2];
`endif

    always #5 clk = ~clk;

    rl_fifo2stream #(.DATA_SIZE(32), .RD_LATENCY(1), .BUF_DEPTH(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr[0]), .fifo_empty_i(empty[0]),
        .fifo_rdena_o(rdena[0]), .fifo_q_i(q0), .m_valid_o(valid[0]),
        .m_ready_i(ready[0]), .m_data_o(d0), .level_o(lvl0)
`ifdef RL_FIFO2STREAM_STATS_EN
        , .xfer_cnt_o(xfer0), .stall_cnt_o(stall0)
`endif
    );

    rl_fifo2stream #(.DATA_SIZE(32), .RD_LATENCY(2), .BUF_DEPTH(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr[1]), .fifo_empty_i(empty[1]),
        .fifo_rdena_o(rdena[1]), .fifo_q_i(q1), .m_valid_o(valid[1]),
        .m_ready_i(ready[1]), .m_data_o(d1), .level_o(lvl1)
`ifdef RL_FIFO2STREAM_STATS_EN
        , .xfer_cnt_o(xfer1), .stall_cnt_o(stall1)
`endif
    );

    logic [31:0] fq   [2][$];
    logic [31:0] expq [2][$];
    logic [31:0] prev_d [2];
    logic [1:0]  rd_s, stalled;
    logic [31:0] st1;
    logic        st1_v;
    int          pops [2], rd_cnt [2], run [2], max_run [2];
    int          tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        fq[k].push_back(w);
        expq[k].push_back(w);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural FIFO: a request seen in a cycle pops the head word, which appears on the read port
    // RD_LATENCY cycles after the request; otherwise the read port carries junk.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            fq[0].delete();
            fq[1].delete();
            st1_v = 1'b0;
            q0    = '0;
            q1    = '0;
        end else begin
            if (rd_s[0] && fq[0].size() > 0) q0 = fq[0].pop_front();
            else                              q0 = $urandom;
            q1    = st1_v ? st1 : $urandom;
            st1_v = 1'b0;
            if (rd_s[1] && fq[1].size() > 0) begin
                st1   = fq[1].pop_front();
                st1_v = 1'b1;
            end
        end
        empty[0] = (fq[0].size() == 0);
        empty[1] = (fq[1].size() == 0);
    end

    task automatic mon(input int k, input logic v, input logic r, input logic rd, input logic e,
                       input logic c, input logic [31:0] d, input int lvl, input int depth);
        string t;
        logic [31:0] w;
        t = (k == 0) ? "d0" : "d1";
        chk({t, "_rd_when_empty"}, {31'b0, rd & e}, 32'd0);
        chk({t, "_rd_during_clr"}, {31'b0, rd & c}, 32'd0);
        chk({t, "_valid_vs_level"}, {31'b0, v}, {31'b0, lvl != 0});
        chk({t, "_level_le_depth"}, {31'b0, lvl <= depth}, 32'd1);
        if (stalled[k]) begin
            chk({t, "_stall_hold_valid"}, {31'b0, v}, 32'd1);
            chk({t, "_stall_hold_data"}, d, prev_d[k]);
        end
        if (v && r) begin
            pops[k]++;
            chk({t, "_word_expected"}, {31'b0, expq[k].size() != 0}, 32'd1);
            if (expq[k].size() != 0) begin
                w = expq[k].pop_front();
                chk({t, "_order"}, d, w);
            end
        end
        if (rd) rd_cnt[k]++;
        if (v) begin
            run[k]++;
            if (run[k] > max_run[k]) max_run[k] = run[k];
        end else run[k] = 0;
        stalled[k] = v & ~r & ~c;
        prev_d[k]  = d;
        rd_s[k]    = rd;
        if (c) begin
            fq[k].delete();
            expq[k].delete();
            empty[k] = 1'b1;
        end
    endtask

`ifdef RL_FIFO2STREAM_STATS_EN
    task automatic stats_upd(input int k, input logic v, input logic r, input logic c);
        if (c) begin
            xfer_m[k]  = '0;
            stall_m[k] = '0;
        end else begin
            if (v && r) xfer_m[k] = xfer_m[k] + 32'd1;
            if (v && !r && stall_m[k] != 32'hFFFF_FFFF) stall_m[k] = stall_m[k] + 32'd1;
        end
    endtask
`endif

    always @(negedge clk) begin
        if (rst) begin
            rd_s    = '0;
            stalled = '0;
            run[0]  = 0;
            run[1]  = 0;
            fq[0].delete();
            fq[1].delete();
            expq[0].delete();
            expq[1].delete();
`ifdef RL_FIFO2STREAM_STATS_EN
            xfer_m  = '{32'd0, 32'd0};
            stall_m = '{32'd0, 32'd0};
`endif
        end else begin
`ifdef RL_FIFO2STREAM_STATS_EN
            chk("d0_xfer_cnt", xfer0, xfer_m[0]);
            chk("d0_stall_cnt", stall0, stall_m[0]);
            chk("d1_xfer_cnt", xfer1, xfer_m[1]);
            chk("d1_stall_cnt", stall1, stall_m[1]);
            stats_upd(0, valid[0], ready[0], clr[0]);
            stats_upd(1, valid[1], ready[1], clr[1]);
`endif
            mon(0, valid[0], ready[0], rdena[0], empty[0], clr[0], d0, int'(lvl0), 2);
            mon(1, valid[1], ready[1], rdena[1], empty[1], clr[1], d1, int'(lvl1), 3);
        end
    end

    task automatic wait_pops(input int k, input int target, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (pops[k] >= target) break;
            cyc(1);
        end
        chk(tag, pops[k], target);
    endtask

    // Behavioural FIFO drops empty in the write cycle, so the count is RD_LATENCY + 2 negedges
    // from the write, i.e. 1 + RD_LATENCY + 1 cycles of FIFO-write-to-valid.
    task automatic lat_check(input int k, input int want, input string tag);
        int n;
        ready[k] = 1'b1;
        push(k, $urandom);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (valid[k]) break;
        end
        chk(tag, n, want);
        cyc(2);
    endtask

    task automatic reset_stats(input int k);
        pops[k]    = 0;
        rd_cnt[k]  = 0;
        max_run[k] = 0;
    endtask

    initial begin
        int base0, base1;
        rst   = 1'b0;
        clr   = '0;
        ready = '0;
        empty = 2'b11;
        q0    = '0;
        q1    = '0;
        st1   = '0;
        st1_v = 1'b0;
        rd_s  = '0;
        stalled = '0;
        for (int k = 0; k < 2; k++) begin
            reset_stats(k);
            run[k]    = 0;
            prev_d[k] = '0;
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", {30'b0, valid}, 32'd0);
        chk("rst_rdena", {30'b0, rdena}, 32'd0);
        chk("rst_level", {28'b0, lvl1, lvl0}, 32'd0);
        chk("rst_data0", d0, 32'd0);
        chk("rst_data1", d1, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // 8-word burst, sink always ready
        reset_stats(0);
        ready[0] = 1'b1;
        for (int i = 1; i <= 8; i++) push(0, 32'(i));
        wait_pops(0, 8, 40, "t1_pops");
        cyc(2);
        chk("t1_valid_run", max_run[0], 8);
        chk("t1_rdena_cycles", rd_cnt[0], 8);
        lat_check(0, 3, "t1_latency");

        // alternating backpressure
        reset_stats(0);
        for (int i = 0; i < 16; i++) push(0, $urandom);
        for (int i = 0; i < 80; i++) begin
            if (pops[0] >= 16) break;
            ready[0] = ~ready[0];
            cyc(1);
        end
        chk("t2_pops", pops[0], 16);
        ready[0] = 1'b1;
        cyc(2);

        // latency 2, depth 3: sustained rate
        reset_stats(1);
        ready[1] = 1'b1;
        for (int i = 0; i < 32; i++) push(1, $urandom);
        wait_pops(1, 32, 100, "t3_pops");
        cyc(2);
        chk("t3_valid_run", max_run[1], 32);
        chk("t3_rdena_cycles", rd_cnt[1], 32);
        lat_check(1, 4, "t3_latency");

        // clear with reads in flight and a word buffered
        ready[1] = 1'b0;
        for (int i = 0; i < 6; i++) push(1, 32'h40 + 32'(i));
        cyc(3);
        clr[1] = 1'b1;
        cyc(1);
        clr[1] = 1'b0;
        chk("t4_valid_after_clr", {31'b0, valid[1]}, 32'd0);
        chk("t4_level_after_clr", {30'b0, lvl1}, 32'd0);
        ready[1] = 1'b1;
        base1 = pops[1];
        cyc(8);
        chk("t4_no_stale_words", pops[1] - base1, 0);
        push(1, 32'h00C0_FFEE);
        wait_pops(1, base1 + 1, 20, "t4_post_clr_word");

        // asynchronous reset mid-stream
        ready = 2'b11;
        for (int i = 0; i < 10; i++) begin
            push(0, $urandom);
            push(1, $urandom);
        end
        cyc(3);
        #3 rst = 1'b1;
        #1;
        chk("t5_valid", {30'b0, valid}, 32'd0);
        chk("t5_rdena", {30'b0, rdena}, 32'd0);
        chk("t5_level", {28'b0, lvl1, lvl0}, 32'd0);
        chk("t5_data0", d0, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        cyc(1);
        base0 = pops[0];
        base1 = pops[1];
        for (int i = 0; i < 4; i++) begin
            push(0, $urandom);
            push(1, $urandom);
        end
        wait_pops(0, base0 + 4, 30, "t5_burst_d0");
        wait_pops(1, base1 + 4, 30, "t5_burst_d1");

        // randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                clr[k]   = ($urandom_range(0, 39) == 0);
                ready[k] = clr[k] ? 1'b0 : ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 2) == 0) push(k, $urandom);
            end
            cyc(1);
        end
        clr   = '0;
        ready = 2'b11;
        for (int i = 0; i < 300; i++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0) break;
            cyc(1);
        end
        cyc(4);
        chk("rand_drain_d0", expq[0].size(), 0);
        chk("rand_drain_d1", expq[1].size(), 0);

`ifdef RL_FIFO2STREAM_STATS_EN
        // 10 transfers with exactly 3 stall cycles, then clear
        ready[0] = 1'b0;
        clr[0]   = 1'b1;
        cyc(1);
        clr[0]   = 1'b0;
        chk("t6_xfer_after_clr", xfer0, 32'd0);
        chk("t6_stall_after_clr", stall0, 32'd0);
        base0 = pops[0];
        for (int i = 0; i < 10; i++) push(0, $urandom);
        for (int i = 0; i < 20; i++) begin
            if (valid[0]) break;
            cyc(1);
        end
        cyc(3);
        ready[0] = 1'b1;
        wait_pops(0, base0 + 10, 40, "t6_pops");
        cyc(1);
        chk("t6_xfer_cnt", xfer0, 32'd10);
        chk("t6_stall_cnt", stall0, 32'd3);
        clr[0] = 1'b1;
        cyc(1);
        clr[0] = 1'b0;
        chk("t6_xfer_cleared", xfer0, 32'd0);
        chk("t6_stall_cleared", stall0, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
